// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: frame states, mode encodings ({CPOL,CPHA}) and edge helper.
package spi_slave_pkg;
  typedef enum logic {SPI_IDLE = 1'b0, SPI_ACTIVE = 1'b1} spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A freshly detected sck edge is a leading edge when it leaves the idle level.
  function automatic logic is_leading(input logic lvl, input logic cpol);
    return lvl != cpol;
  endfunction
endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a third flop for edge detection; level is the synced value.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {3{RST_VAL}};
    else        sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_slave.sv
// SPI responder sampled in the clk domain (f_clk >= 4*f_sck).
// Optional sticky status flags when SPI_SLAVE_STATUS_EN is defined.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic                  CPOL       = 1'b0,
  parameter logic                  CPHA       = 1'b0,
  parameter logic                  MSB_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] DUMMY      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic                  status_clr,
  output logic                  tx_underrun,
  output logic                  rx_overrun
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam int DW = DATA_WIDTH;

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl;
  logic [1:0] mosi_edge_unused;

  spi_sync #(.RST_VAL(CPOL)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  // cs_n resets to "selected" so a pin held low across reset never looks like a fresh fall.
  spi_sync #(.RST_VAL(1'b0)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_lvl), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1]));

  spi_state_t state, state_nxt;
  logic frame_start, frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SPI_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      SPI_IDLE:   if (cs_fall) begin state_nxt = SPI_ACTIVE; frame_start = 1'b1; end
      SPI_ACTIVE: if (cs_rise) begin state_nxt = SPI_IDLE;   frame_end   = 1'b1; end
      default:    state_nxt = SPI_IDLE;
    endcase
  end

  logic sck_edge, lead, trail, run, samp, shft;
  assign sck_edge = sck_rise | sck_fall;
  assign lead     = sck_edge & is_leading(sck_lvl, CPOL);
  assign trail    = sck_edge & ~is_leading(sck_lvl, CPOL);
  assign run      = (state == SPI_ACTIVE) & ~cs_lvl;
  assign samp     = run & (CPHA ? trail : lead);
  assign shft     = run & (CPHA ? lead : trail);

  logic [DW-1:0] tx_buf, tsr, rsr, word_nxt, rx_nxt;
  logic          tx_fresh, need_load, copy, word_done;
  logic [CW-1:0] cnt;

  assign word_nxt  = tx_fresh ? tx_buf : DUMMY;
  assign copy      = frame_start | (shft & need_load);
  assign word_done = samp & (cnt == LAST);
  assign rx_nxt    = MSB_FIRST ? {rsr[DW-2:0], mosi_lvl} : {mosi_lvl, rsr[DW-1:1]};

  function automatic logic first_of(input logic [DW-1:0] w);
    return MSB_FIRST ? w[DW-1] : w[0];
  endfunction

  function automatic logic [DW-1:0] rest_of(input logic [DW-1:0] w);
    return MSB_FIRST ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
  endfunction

  // A load in the same cycle as a copy wins: the copy already took the old buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf   <= DUMMY;
      tx_fresh <= 1'b0;
    end else if (tx_load) begin
      tx_buf   <= tx_data;
      tx_fresh <= 1'b1;
    end else if (copy) begin
      tx_fresh <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      tsr       <= '0;
      rsr       <= '0;
      cnt       <= '0;
      need_load <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (frame_start) begin
        cnt       <= '0;
        need_load <= 1'b0;
        if (!CPHA) begin
          miso <= first_of(word_nxt);
          tsr  <= rest_of(word_nxt);
        end else begin
          tsr  <= word_nxt;
        end
      end else if (frame_end) begin
        cnt       <= '0;
        need_load <= 1'b0;
        miso      <= 1'b0;
      end else begin
        if (shft) begin
          if (need_load) begin
            miso      <= first_of(word_nxt);
            tsr       <= rest_of(word_nxt);
            need_load <= 1'b0;
          end else begin
            miso <= first_of(tsr);
            tsr  <= rest_of(tsr);
          end
        end
        if (samp) begin
          rsr <= rx_nxt;
          if (word_done) begin
            rx_data   <= rx_nxt;
            rx_valid  <= 1'b1;
            cnt       <= '0;
            need_load <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

  assign tx_ready = ~tx_fresh;
  assign miso_oe  = (state == SPI_ACTIVE);
  assign busy     = miso_oe;

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_unread;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_unread   <= 1'b0;
    end else begin
      if (copy && !tx_fresh)           tx_underrun <= 1'b1;
      else if (status_clr)             tx_underrun <= 1'b0;
      if (word_done && rx_unread)      rx_overrun  <= 1'b1;
      else if (status_clr)             rx_overrun  <= 1'b0;
      if (word_done)                   rx_unread   <= 1'b1;
      else if (status_clr)             rx_unread   <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: mode-0 and mode-3 responders driven by a bit-banged master, scoreboarded rx/miso words.
module tb_spi_slave;
  logic clk = 1'b0, rst_n = 1'b0, ph = 1'b0;
  logic sck0, sck1, cs_n0 = 1'b1, cs_n1 = 1'b1, mosi = 1'b0;
  logic [15:0] tx_data = '0;
  logic tx_load0 = 1'b0, tx_load1 = 1'b0;
  logic miso0, miso1, oe0, oe1, tx_ready0, tx_ready1, rx_valid0, rx_valid1, busy0, busy1;
  logic [15:0] rx_data0, rx_data1;
`ifdef SPI_SLAVE_STATUS_EN
  logic status_clr0 = 1'b0, status_clr1 = 1'b0, und0, ovr0, und1, ovr1;
`endif

  assign sck0 = ph;
  assign sck1 = ~ph;
  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .cs_n(cs_n0), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .tx_data(tx_data), .tx_load(tx_load0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(status_clr0), .tx_underrun(und0), .rx_overrun(ovr0)
`endif
  );

  spi_slave #(.DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck1), .cs_n(cs_n1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .tx_data(tx_data), .tx_load(tx_load1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(status_clr1), .tx_underrun(und1), .rx_overrun(ovr1)
`endif
  );

  int tests = 0, fails = 0, npulse = 0;
  logic [15:0] exp_rx[$];
  logic [15:0] exp_miso[$];
  logic [15:0] mw[4];
  int h1 = -1, h2 = -1, chk_half = -1, rst_bit = -1;
  logic [15:0] d1 = '0, d2 = '0;
  logic chk_val = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rx scoreboard: every rx_valid pulse must match the next word the master sent
  always @(negedge clk) begin
    if (rst_n && (rx_valid0 || rx_valid1)) begin
      npulse++;
      if (exp_rx.size() == 0) begin
        tests++;
        assert (exp_rx.size() != 0) else begin
          fails++;
          $error("FAIL rx_unexpected: observed %0h expected no word", rx_valid0 ? rx_data0 : rx_data1);
        end
      end else begin
        chk("rx_word", rx_valid0 ? rx_data0 : rx_data1, exp_rx.pop_front());
      end
    end
  end

  task automatic load(input int sel, input logic [15:0] d);
    @(negedge clk);
    tx_data = d;
    if (sel == 0) tx_load0 = 1'b1; else tx_load1 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0; tx_load1 = 1'b0;
  endtask

  // One sck half-period (4 clk); a hooked load lands on the cycle the DUT acts on the edge.
  task automatic half(input int sel, input int hidx);
    repeat (2) @(negedge clk);
    if (hidx == h1 || hidx == h2) begin
      tx_data = (hidx == h1) ? d1 : d2;
      if (sel == 0) tx_load0 = 1'b1; else tx_load1 = 1'b1;
    end
    @(negedge clk);
    tx_load0 = 1'b0; tx_load1 = 1'b0;
    if (hidx == chk_half) chk("tx_ready_hold", sel ? tx_ready1 : tx_ready0, chk_val);
    @(negedge clk);
  endtask

  task automatic run_frame(input int sel, input int nw, input int cut);
    int nbits, hidx;
    logic [15:0] cur;
    nbits = (cut > 0) ? cut : nw * 16;
    hidx = 0;
    cur = '0;
    if (cut == 0) for (int w = 0; w < nw; w++) exp_rx.push_back(mw[w]);
    @(negedge clk);
    if (sel == 0) begin mosi = mw[0][15]; cs_n0 = 1'b0; end
    else cs_n1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_active", sel ? busy1 : busy0, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        #1;
        chk("rst_miso", miso0, 1'b0);
        chk("rst_oe", oe0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_tx_ready", tx_ready0, 1'b1);
        chk("rst_rx_data", rx_data0, 16'h0000);
        chk("rst_rx_valid", rx_valid0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (sel == 0) begin
        cur = {cur[14:0], miso0};
        ph = 1'b1; half(sel, hidx); hidx++;
        ph = 1'b0;
        if (i + 1 < nbits) mosi = mw[(i + 1) / 16][15 - ((i + 1) % 16)];
        half(sel, hidx); hidx++;
      end else begin
        ph = 1'b1; mosi = mw[i / 16][15 - (i % 16)];
        half(sel, hidx); hidx++;
        cur = {cur[14:0], miso1};
        ph = 1'b0; half(sel, hidx); hidx++;
      end
      if (cut == 0 && (i % 16) == 15) begin
        if (exp_miso.size() == 0) chk("miso_no_expect", cur, 32'hFFFF_FFFF);
        else chk("miso_word", cur, exp_miso.pop_front());
      end
    end
    if (sel == 0) cs_n0 = 1'b1; else cs_n1 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hold_oe", oe0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_miso", miso0, 1'b0);
    chk("reset_oe", oe0, 1'b0);
    chk("reset_tx_ready", tx_ready0, 1'b1);
    chk("reset_rx_data", rx_data0, 16'h0000);
    chk("reset_rx_valid", rx_valid0, 1'b0);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_tx_ready1", tx_ready1, 1'b1);

    // mode 0 single word
    load(0, 16'hA5C3);
    chk("tx_ready_after_load", tx_ready0, 1'b0);
    mw[0] = 16'h1234; exp_miso.push_back(16'hA5C3);
    run_frame(0, 1, 0);
    chk("busy_idle", busy0, 1'b0);
    chk("rx_data_a", rx_data0, 16'h1234);
    chk("tx_ready_after_frame", tx_ready0, 1'b1);

    // mode 3, two back-to-back words, second tx word loaded mid-frame
    load(1, 16'h1111);
    h1 = 5; d1 = 16'h2222;
    mw[0] = 16'hBEEF; mw[1] = 16'h0F0F;
    exp_miso.push_back(16'h1111); exp_miso.push_back(16'h2222);
    run_frame(1, 2, 0);
    h1 = -1;
    chk("rx_data_b", rx_data1, 16'h0F0F);
    chk("busy1_idle", busy1, 1'b0);

    // no load: DUMMY word
    mw[0] = 16'h5A5A; exp_miso.push_back(16'h0000);
    run_frame(0, 1, 0);
    chk("rx_data_c", rx_data0, 16'h5A5A);
`ifdef SPI_SLAVE_STATUS_EN
    chk("underrun_set", und0, 1'b1);
    chk("overrun_set", ovr0, 1'b1);
    @(negedge clk); status_clr0 = 1'b1;
    @(negedge clk); status_clr0 = 1'b0;
    chk("underrun_clr", und0, 1'b0);
    chk("overrun_clr", ovr0, 1'b0);
`endif

    // partial word aborted by cs_n, then a full word
    load(0, 16'hABCD);
    mw[0] = 16'hFFFF;
    run_frame(0, 1, 7);
    chk("rx_data_partial", rx_data0, 16'h5A5A);
    chk("busy_after_partial", busy0, 1'b0);
    mw[0] = 16'h00FF; exp_miso.push_back(16'h0000);
    run_frame(0, 1, 0);
    chk("rx_data_d", rx_data0, 16'h00FF);

    // async reset mid-word, then a clean frame
    load(0, 16'h1357);
    h1 = 1; d1 = 16'h2468; rst_bit = 5;
    mw[0] = 16'hFFFF;
    run_frame(0, 1, 9);
    h1 = -1; rst_bit = -1;
    chk("tx_ready_post_rst", tx_ready0, 1'b1);
    chk("rx_data_post_rst", rx_data0, 16'h0000);
    load(0, 16'h7E81);
    mw[0] = 16'hC3C3; exp_miso.push_back(16'h7E81);
    run_frame(0, 1, 0);
    chk("rx_data_e", rx_data0, 16'hC3C3);

    // load coinciding with the word-boundary copy
    load(0, 16'h1111);
    h1 = 3; d1 = 16'h2222; h2 = 31; d2 = 16'h3333;
    chk_half = 40; chk_val = 1'b0;
    mw[0] = 16'h0101; mw[1] = 16'h0202; mw[2] = 16'h0303;
    exp_miso.push_back(16'h1111); exp_miso.push_back(16'h2222); exp_miso.push_back(16'h3333);
    run_frame(0, 3, 0);
    h1 = -1; h2 = -1; chk_half = -1;
    chk("rx_data_f", rx_data0, 16'h0303);
    chk("tx_ready_end_f", tx_ready0, 1'b1);

    repeat (4) @(negedge clk);
    chk("rx_pulse_count", npulse, 9);
    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("miso_queue_empty", exp_miso.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
